gray_updown_counter: RTL and testbench

Parametrised synchronous up/down counter that keeps binary and Gray-coded count registers in lockstep, with parallel load, wrap or saturate behaviour and a cascade-ready terminal-count output. It generalises the team's fixed 3-bit direction-controlled Gray counter to any width. It also adds load, enable and end-of-range handling. It sits in lab-level datapaths wherever a stepping Gray sequence drives displays, encoders or FSM sequencers.

---
 rtl/gray_counter_pkg.sv | 27 ++
 rtl/dff_ar.sv | 26 ++
 rtl/gray_updown_counter.sv | 124 ++++++++++++
 tb/tb_gray_updown_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_pkg
// Description : Shared constants and Gray-encode helper for the Gray up/down
//               counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_counter_pkg;

    // Widest counter the family supports; bin2gray works at this width and
    // callers zero-extend / slice to their own WIDTH.
    localparam int GRAY_MAX_WIDTH = 16;

    // Direction encoding for the dir input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Binary-to-Gray conversion. Zero-extended inputs give zero upper bits,
    // so the caller's slice of the low WIDTH bits is the WIDTH-bit Gray code.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage : gray_counter_pkg
`default_nettype wire

// File: rtl/dff_ar.sv
`default_nettype none
// ============================================================================
// Module      : dff_ar
// Description : WIDTH-bit D register, asynchronous active-high reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ar #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on every rising edge; reset clears immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : dff_ar
`default_nettype wire

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_updown_counter
// Description : Parametrised up/down counter keeping binary and Gray-coded
//               registers in lockstep, with parallel load, wrap or saturate
//               at the range ends and a combinational terminal-count output
//               for cascading (upper stage en = lower stage tc).
//               Optional macro GRAY_COUNTER_SYNC_CLEAR_EN adds a synchronous
//               clear input clr with priority above load.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_updown_counter
    import gray_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
    input  logic             clr,
`endif
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_bin,
    output logic [WIDTH-1:0] count_gray,
    output logic             tc,
    output logic             wrapped
);

    logic                      clr_active;
    logic                      at_max;
    logic                      at_min;
    logic                      at_end;
    logic [WIDTH-1:0]          bin_inc;
    logic [WIDTH-1:0]          bin_dec;
    logic [WIDTH-1:0]          bin_step;
    logic [WIDTH-1:0]          bin_next;
    logic [WIDTH-1:0]          gray_next;
    logic [GRAY_MAX_WIDTH-1:0] gray_full;
    logic                      wrapped_next;

`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
    assign clr_active = clr;
`else
    assign clr_active = 1'b0;
`endif

    // Range-end detection against the registered count.
    assign at_max = &count_bin;
    assign at_min = ~|count_bin;
    assign at_end = (dir == DIR_UP) ? at_max : at_min;

    // WIDTH-bit step; carry/borrow drops out, giving modulo-2^WIDTH wrap.
    assign bin_inc  = count_bin + WIDTH'(1);
    assign bin_dec  = count_bin - WIDTH'(1);
    assign bin_step = (dir == DIR_DOWN) ? bin_dec : bin_inc;

    // Terminal count uses the live en/dir so a cascaded stage steps on the
    // same edge the lower stage rolls over.
    assign tc = en & at_end;

    // Next-state priority mux: clr > load > en > hold.
    always_comb begin
        bin_next     = count_bin;
        wrapped_next = 1'b0;
        if (clr_active) begin
            bin_next = '0;
        end else if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (!at_end) begin
                bin_next = bin_step;
            end else if (SATURATE == 0) begin
                bin_next     = bin_step;
                wrapped_next = 1'b1;
            end
        end
    end

    // Gray register is loaded from the encoded next binary value, so the two
    // registers can never disagree.
    assign gray_full = bin2gray(GRAY_MAX_WIDTH'(bin_next));
    assign gray_next = gray_full[WIDTH-1:0];

    generate
        if (WIDTH < GRAY_MAX_WIDTH) begin : g_gray_pad
            // Upper bits of the shared-width encoder are always zero here.
            logic unused_gray_hi;
            assign unused_gray_hi = |gray_full[GRAY_MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    dff_ar #(
        .WIDTH (WIDTH)
    ) u_bin_reg (
        .clk   (clk),
        .reset (reset),
        .d     (bin_next),
        .q     (count_bin)
    );

    dff_ar #(
        .WIDTH (WIDTH)
    ) u_gray_reg (
        .clk   (clk),
        .reset (reset),
        .d     (gray_next),
        .q     (count_gray)
    );

    dff_ar #(
        .WIDTH (1)
    ) u_wrap_reg (
        .clk   (clk),
        .reset (reset),
        .d     (wrapped_next),
        .q     (wrapped)
    );

endmodule : gray_updown_counter
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_updown_counter
// Description : Directed bench for gray_updown_counter: a 3-bit wrapping
//               instance (a_*) and a 4-bit saturating instance (b_*).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_clr = 1'b0;
    logic       a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0;
    logic [2:0] a_load_val = '0;
    logic [2:0] a_bin, a_gray;
    logic       a_tc, a_wrapped;

    logic       b_clr = 1'b0;
    logic       b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0;
    logic [3:0] b_load_val = '0;
    logic [3:0] b_bin, b_gray;
    logic       b_tc, b_wrapped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(3), .SATURATE(0)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
        .clr        (a_clr),
`endif
        .en         (a_en),
        .dir        (a_dir),
        .load       (a_load),
        .load_val   (a_load_val),
        .count_bin  (a_bin),
        .count_gray (a_gray),
        .tc         (a_tc),
        .wrapped    (a_wrapped)
    );

    gray_updown_counter #(.WIDTH(4), .SATURATE(1)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
        .clr        (b_clr),
`endif
        .en         (b_en),
        .dir        (b_dir),
        .load       (b_load),
        .load_val   (b_load_val),
        .count_bin  (b_bin),
        .count_gray (b_gray),
        .tc         (b_tc),
        .wrapped    (b_wrapped)
    );

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++; if (a_bin !== 3'd0) begin bad++; $display("FAIL reset_a_bin got=%0d want=0", a_bin); end
        total++; if (a_gray !== 3'd0) begin bad++; $display("FAIL reset_a_gray got=%b want=000", a_gray); end
        total++; if (a_wrapped !== 1'b0) begin bad++; $display("FAIL reset_a_wrapped got=%b want=0", a_wrapped); end
        total++; if (b_bin !== 4'd0) begin bad++; $display("FAIL reset_b_bin got=%0d want=0", b_bin); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp_gray [0:8];
        exp_gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        a_en = 1'b1; a_dir = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] prev;
            prev = 3'(i - 1);
            total++; if (a_tc !== (prev == 3'd7)) begin bad++; $display("FAIL up_tc step=%0d got=%b want=%b", i, a_tc, prev == 3'd7); end
            tick();
            total++; if (a_bin !== 3'(i)) begin bad++; $display("FAIL up_bin step=%0d got=%0d want=%0d", i, a_bin, 3'(i)); end
            total++; if (a_gray !== exp_gray[i]) begin bad++; $display("FAIL up_gray step=%0d got=%b want=%b", i, a_gray, exp_gray[i]); end
            total++; if (a_wrapped !== (i == 8)) begin bad++; $display("FAIL up_wrapped step=%0d got=%b want=%b", i, a_wrapped, i == 8); end
        end
    endtask

    task automatic test_down_wrap();
        a_dir = 1'b1;
        #1;
        total++; if (a_tc !== 1'b1) begin bad++; $display("FAIL down_tc_at0 got=%b want=1", a_tc); end
        tick();
        total++; if (a_bin !== 3'd7) begin bad++; $display("FAIL down_bin1 got=%0d want=7", a_bin); end
        total++; if (a_gray !== 3'b100) begin bad++; $display("FAIL down_gray1 got=%b want=100", a_gray); end
        total++; if (a_wrapped !== 1'b1) begin bad++; $display("FAIL down_wrapped1 got=%b want=1", a_wrapped); end
        total++; if (a_tc !== 1'b0) begin bad++; $display("FAIL down_tc_at7 got=%b want=0", a_tc); end
        tick();
        total++; if (a_bin !== 3'd6) begin bad++; $display("FAIL down_bin2 got=%0d want=6", a_bin); end
        total++; if (a_gray !== 3'b101) begin bad++; $display("FAIL down_gray2 got=%b want=101", a_gray); end
        total++; if (a_wrapped !== 1'b0) begin bad++; $display("FAIL down_wrapped2 got=%b want=0", a_wrapped); end
    endtask

    task automatic test_load_priority();
        a_dir = 1'b0; a_en = 1'b1;
        a_load = 1'b1; a_load_val = 3'd2;
        tick();
        total++; if (a_bin !== 3'd2) begin bad++; $display("FAIL load2_bin got=%0d want=2", a_bin); end
        a_load_val = 3'd5;
        tick();
        total++; if (a_bin !== 3'd5) begin bad++; $display("FAIL load5_bin got=%0d want=5", a_bin); end
        total++; if (a_gray !== 3'b111) begin bad++; $display("FAIL load5_gray got=%b want=111", a_gray); end
        a_load = 1'b0;
        tick();
        total++; if (a_bin !== 3'd6) begin bad++; $display("FAIL after_load_bin got=%0d want=6", a_bin); end
        total++; if (a_gray !== 3'b101) begin bad++; $display("FAIL after_load_gray got=%b want=101", a_gray); end
        tick();
        // Count is 7 with en=1, dir=0: terminal; a load here must win.
        total++; if (a_tc !== 1'b1) begin bad++; $display("FAIL tc_at7 got=%b want=1", a_tc); end
        a_load = 1'b1; a_load_val = 3'd7;
        tick();
        total++; if (a_bin !== 3'd7) begin bad++; $display("FAIL load_at_tc_bin got=%0d want=7", a_bin); end
        total++; if (a_wrapped !== 1'b0) begin bad++; $display("FAIL load_at_tc_wrapped got=%b want=0", a_wrapped); end
        a_load = 1'b0;
    endtask

    task automatic test_hold();
        a_en = 1'b0;
        #1;
        total++; if (a_tc !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b want=0", a_tc); end
        tick();
        total++; if (a_bin !== 3'd7) begin bad++; $display("FAIL hold_bin got=%0d want=7", a_bin); end
        total++; if (a_gray !== 3'b100) begin bad++; $display("FAIL hold_gray got=%b want=100", a_gray); end
        total++; if (a_wrapped !== 1'b0) begin bad++; $display("FAIL hold_wrapped got=%b want=0", a_wrapped); end
    endtask

    task automatic test_saturate();
        b_load = 1'b1; b_load_val = 4'd14;
        tick();
        total++; if (b_bin !== 4'd14) begin bad++; $display("FAIL sat_load_bin got=%0d want=14", b_bin); end
        b_load = 1'b0; b_en = 1'b1; b_dir = 1'b0;
        tick();
        total++; if (b_bin !== 4'd15) begin bad++; $display("FAIL sat_up_bin got=%0d want=15", b_bin); end
        total++; if (b_tc !== 1'b1) begin bad++; $display("FAIL sat_tc got=%b want=1", b_tc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (b_bin !== 4'd15) begin bad++; $display("FAIL sat_hold_bin edge=%0d got=%0d want=15", i, b_bin); end
            total++; if (b_gray !== 4'b1000) begin bad++; $display("FAIL sat_hold_gray edge=%0d got=%b want=1000", i, b_gray); end
            total++; if (b_wrapped !== 1'b0) begin bad++; $display("FAIL sat_wrapped edge=%0d got=%b want=0", i, b_wrapped); end
        end
        b_dir = 1'b1;
        tick();
        total++; if (b_bin !== 4'd14) begin bad++; $display("FAIL sat_down_bin got=%0d want=14", b_bin); end
        total++; if (b_gray !== 4'b1001) begin bad++; $display("FAIL sat_down_gray got=%b want=1001", b_gray); end
        b_en = 1'b0; b_load = 1'b1; b_load_val = 4'd1;
        tick();
        b_load = 1'b0; b_en = 1'b1;
        tick();
        total++; if (b_bin !== 4'd0) begin bad++; $display("FAIL sat_down_to0 got=%0d want=0", b_bin); end
        tick();
        total++; if (b_bin !== 4'd0) begin bad++; $display("FAIL sat_hold0 got=%0d want=0", b_bin); end
        total++; if (b_wrapped !== 1'b0) begin bad++; $display("FAIL sat_hold0_wrapped got=%b want=0", b_wrapped); end
        b_en = 1'b0;
    endtask

    task automatic test_async_reset();
        a_load = 1'b1; a_load_val = 3'd6;
        tick();
        a_load = 1'b0; a_en = 1'b1; a_dir = 1'b0;
        total++; if (a_bin !== 3'd6) begin bad++; $display("FAIL prereset_bin got=%0d want=6", a_bin); end
        #2 reset = 1'b1;
        #1;
        total++; if (a_bin !== 3'd0) begin bad++; $display("FAIL async_reset_bin got=%0d want=0", a_bin); end
        total++; if (a_gray !== 3'd0) begin bad++; $display("FAIL async_reset_gray got=%b want=000", a_gray); end
        #1 reset = 1'b0;
        tick();
        total++; if (a_bin !== 3'd1) begin bad++; $display("FAIL post_reset_bin got=%0d want=1", a_bin); end
        total++; if (a_gray !== 3'b001) begin bad++; $display("FAIL post_reset_gray got=%b want=001", a_gray); end
        a_en = 1'b0;
    endtask

`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
    task automatic test_clr();
        a_load = 1'b1; a_load_val = 3'd3;
        tick();
        a_clr = 1'b1; a_load = 1'b1; a_load_val = 3'd5; a_en = 1'b1;
        tick();
        a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0;
        total++; if (a_bin !== 3'd0) begin bad++; $display("FAIL clr_bin got=%0d want=0", a_bin); end
        total++; if (a_gray !== 3'd0) begin bad++; $display("FAIL clr_gray got=%b want=000", a_gray); end
        total++; if (a_wrapped !== 1'b0) begin bad++; $display("FAIL clr_wrapped got=%b want=0", a_wrapped); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_hold();
        test_saturate();
        test_async_reset();
`ifdef GRAY_COUNTER_SYNC_CLEAR_EN
        test_clr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gray_updown_counter
`default_nettype wire
